// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan driver
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam int         NIB_W   = 4;

  // Bit offset of digit idx inside the packed display value.
  function automatic int nib_lsb(input int idx);
    return NIB_W * idx;
  endfunction

endpackage

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - combinational hex nibble to active-low {g,f,e,d,c,b,a} segments
module hex_decoder (
  input  logic [3:0] i_num,
  output logic [6:0] o_seg7
);

  always_comb begin
    o_seg7 = 7'h7F;
    case (i_num)
      4'h0: o_seg7 = 7'h40;
      4'h1: o_seg7 = 7'h79;
      4'h2: o_seg7 = 7'h24;
      4'h3: o_seg7 = 7'h30;
      4'h4: o_seg7 = 7'h19;
      4'h5: o_seg7 = 7'h12;
      4'h6: o_seg7 = 7'h02;
      4'h7: o_seg7 = 7'h78;
      4'h8: o_seg7 = 7'h00;
      4'h9: o_seg7 = 7'h10;
      4'hA: o_seg7 = 7'h08;
      4'hB: o_seg7 = 7'h03;
      4'hC: o_seg7 = 7'h46;
      4'hD: o_seg7 = 7'h21;
      4'hE: o_seg7 = 7'h06;
      4'hF: o_seg7 = 7'h0E;
      default: o_seg7 = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode display scanner with frame-aligned updates
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic                  i_load,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_blank_lz,
  output logic [DIGITS-1:0]     o_anode,
  output logic [6:0]            o_seg7,
  output logic                  o_dp,
  output logic                  o_frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]     GUARD_END = PW'(GUARD);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF = '1;
  localparam logic [DIGITS-1:0] ONE_HOT   = DIGITS'(1);

  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow, disp;
  logic [DIGITS-1:0]   shadow_dp, disp_dp;
  logic                pend;

  logic                pre_tc, end_of_frame, blank, on;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   nib_zero, zero_from;

  assign pre_tc       = (prescaler == PRE_LAST);
  assign end_of_frame = pre_tc && (idx == IDX_LAST);
  assign nib          = disp[nib_lsb(int'(idx)) +: 4];

  hex_decoder u_hex_decoder (
    .i_num  (nib),
    .o_seg7 (dec_seg)
  );

  // zero_from[k]: every nibble from the top digit down to k is zero.
  always_comb begin
    nib_zero  = '0;
    zero_from = '0;
    for (int k = 0; k < DIGITS; k++)
      nib_zero[k] = (disp[nib_lsb(k) +: 4] == 4'h0);
    zero_from[DIGITS-1] = nib_zero[DIGITS-1];
    for (int k = DIGITS - 2; k >= 0; k--)
      zero_from[k] = nib_zero[k] & zero_from[k+1];
  end

  assign blank = i_blank_lz && (idx != '0) && zero_from[idx];
  assign on    = (prescaler >= GUARD_END) && !blank;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pend      <= 1'b0;
      o_anode   <= ANODE_OFF;
      o_seg7    <= SEG_OFF;
      o_dp      <= 1'b1;
      o_frame   <= 1'b0;
    end else begin
      prescaler <= pre_tc ? '0 : prescaler + 1'b1;
      if (pre_tc)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // disp only moves on the frame boundary so a frame never mixes two values.
      if (i_load) begin
        shadow    <= i_value;
        shadow_dp <= i_dp;
        if (end_of_frame) begin
          disp    <= i_value;
          disp_dp <= i_dp;
          pend    <= 1'b0;
        end else begin
          pend    <= 1'b1;
        end
      end else if (end_of_frame && pend) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
        pend    <= 1'b0;
      end

      o_anode <= on ? ~(ONE_HOT << idx) : ANODE_OFF;
      o_seg7  <= on ? dec_seg : SEG_OFF;
      o_dp    <= on ? ~disp_dp[idx] : 1'b1;
      o_frame <= end_of_frame;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a time-based reference model
module tb_seg7_scan_driver;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_value = '0;
  logic        i_load = 1'b0;
  logic [3:0]  i_dp = '0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  o_anode;
  logic [6:0]  o_seg7;
  logic        o_dp;
  logic        o_frame;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .o_anode    (o_anode),
    .o_seg7     (o_seg7),
    .o_dp       (o_dp),
    .o_frame    (o_frame)
  );

  always #5 i_clk = ~i_clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0;
  int fails = 0;

  // Model: scan position follows from cycles elapsed since reset release.
  int          t = 0;
  logic [15:0] mdisp = '0, mshadow = '0;
  logic [3:0]  mdp = '0, mshadow_dp = '0;
  bit          mpend = 0;

  int          cyc = 0, last_frame = -1, last_period = 0;
  int          low_cnt [4];
  logic [6:0]  seg_seen [4];
  int          dp_in_b = 0, dp_out_b = 0;
  int          n;
  bit          found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    for (int k = 0; k < 4; k++) begin
      low_cnt[k]  = 0;
      seg_seen[k] = 7'h7F;
    end
    dp_in_b  = 0;
    dp_out_b = 0;
  endtask

  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr;
    int         slot, pos;
    bit         eof, blank, on;
    slot = (t / 8) % 4;
    pos  = t % 8;
    eof  = (pos == 7) && (slot == 3);
    if (i_reset) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      blank = (slot > 0) && i_blank_lz && ((mdisp >> (4 * slot)) == 16'h0);
      on    = (pos >= 2) && !blank;
      e_an  = on ? ~(4'b0001 << slot) : 4'hF;
      e_seg = on ? seg_tab[(mdisp >> (4 * slot)) & 16'hF] : 7'h7F;
      e_dp  = on ? ~mdp[slot] : 1'b1;
      e_fr  = eof;
    end
    if (i_reset) begin
      t = 0; mdisp = '0; mshadow = '0; mdp = '0; mshadow_dp = '0; mpend = 0;
    end else begin
      if (i_load && eof) begin
        mdisp = i_value; mdp = i_dp; mshadow = i_value; mshadow_dp = i_dp; mpend = 0;
      end else if (i_load) begin
        mshadow = i_value; mshadow_dp = i_dp; mpend = 1;
      end else if (eof && mpend) begin
        mdisp = mshadow; mdp = mshadow_dp; mpend = 0;
      end
      t++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    chk("anode", 32'(o_anode), 32'(e_an));
    chk("seg7",  32'(o_seg7),  32'(e_seg));
    chk("dp",    32'(o_dp),    32'(e_dp));
    chk("frame", 32'(o_frame), 32'(e_fr));
    for (int k = 0; k < 4; k++)
      if (o_anode[k] === 1'b0) begin
        low_cnt[k]++;
        seg_seen[k] = o_seg7;
      end
    if (o_dp === 1'b0) begin
      if (o_anode === 4'hB) dp_in_b++;
      else dp_out_b++;
    end
    if (o_frame === 1'b1) begin
      if (last_frame >= 0) last_period = cyc - last_frame;
      last_frame = cyc;
    end
    i_load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wait_frame(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      tick();
      got = (o_frame === 1'b1);
    end
    if (!got) chk({tag, "_frame_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    i_value = v;
    i_dp    = dp;
    i_load  = 1'b1;
    tick();
  endtask

  initial begin
    // 1: reset state and release latency
    run(3);
    chk("rst_anode", 32'(o_anode), 32'hF);
    chk("rst_seg7",  32'(o_seg7),  32'h7F);
    chk("rst_dp",    32'(o_dp),    32'h1);
    i_reset = 1'b0;
    n = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      n++;
      found = (o_anode !== 4'hF);
    end
    chk("first_anode_latency", 32'(n), 32'd3);
    chk("first_anode", 32'(o_anode), 32'hE);

    // 2: full frame of 12AF
    load(16'h12AF, 4'h0);
    wait_frame("t2a");
    clear_tally();
    run(32);
    for (int k = 0; k < 4; k++) chk("t2_low_cycles", 32'(low_cnt[k]), 32'd6);
    chk("t2_seg_d0", 32'(seg_seen[0]), 32'h0E);
    chk("t2_seg_d1", 32'(seg_seen[1]), 32'h08);
    chk("t2_seg_d2", 32'(seg_seen[2]), 32'h24);
    chk("t2_seg_d3", 32'(seg_seen[3]), 32'h79);
    chk("t2_frame_period", 32'(last_period), 32'd32);

    // 3: mid-frame load waits for the boundary
    load(16'h0000, 4'h0);
    wait_frame("t3a");
    run(10);
    load(16'h1234, 4'h0);
    clear_tally();
    wait_frame("t3b");
    chk("t3_old_d3", 32'(seg_seen[3]), 32'h40);
    chk("t3_old_d2", 32'(seg_seen[2]), 32'h40);
    clear_tally();
    run(32);
    chk("t3_new_d0", 32'(seg_seen[0]), 32'h19);
    chk("t3_new_d3", 32'(seg_seen[3]), 32'h79);

    // 4: leading-zero blanking
    i_blank_lz = 1'b1;
    load(16'h0050, 4'h0);
    wait_frame("t4a");
    clear_tally();
    run(32);
    chk("t4_d3_off", 32'(low_cnt[3]), 32'd0);
    chk("t4_d2_off", 32'(low_cnt[2]), 32'd0);
    chk("t4_d1_seg", 32'(seg_seen[1]), 32'h12);
    chk("t4_d0_seg", 32'(seg_seen[0]), 32'h40);
    load(16'h0000, 4'h0);
    wait_frame("t4b");
    clear_tally();
    run(32);
    chk("t4z_d1_off", 32'(low_cnt[1] + low_cnt[2] + low_cnt[3]), 32'd0);
    chk("t4z_d0_seg", 32'(seg_seen[0]), 32'h40);
    i_blank_lz = 1'b0;

    // 5: decimal point only on digit 2
    load(16'h8888, 4'b0100);
    wait_frame("t5a");
    clear_tally();
    run(32);
    chk("t5_dp_on_d2", 32'(dp_in_b), 32'd6);
    chk("t5_dp_elsewhere", 32'(dp_out_b), 32'd0);

    // load coinciding with the frame boundary takes effect immediately
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (t % 32 == 31) found = 1;
      else tick();
    end
    load(16'hC0DE, 4'b0001);
    run(32);

    // randomized loads, dp and blanking
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        i_value = 16'($urandom);
        if ($urandom_range(0, 1) == 1) i_value = i_value & 16'h00FF;
        i_dp    = 4'($urandom);
        i_load  = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) i_blank_lz = ~i_blank_lz;
      tick();
    end

    // 6: reset mid-slot of digit 2
    i_blank_lz = 1'b0;
    load(16'h5A5A, 4'hF);
    wait_frame("t6a");
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (t % 32 == 20) found = 1;
      else tick();
    end
    chk("t6_reached_d2", 32'(found), 32'd1);
    i_reset = 1'b1;
    tick();
    chk("t6_anode", 32'(o_anode), 32'hF);
    chk("t6_seg7",  32'(o_seg7),  32'h7F);
    chk("t6_dp",    32'(o_dp),    32'h1);
    chk("t6_frame", 32'(o_frame), 32'h0);
    i_reset = 1'b0;
    run(3);
    chk("t6_resume_anode", 32'(o_anode), 32'hE);
    chk("t6_resume_seg7",  32'(o_seg7),  32'h40);
    run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
